mii_phy_decoder: RTL
====================

MII_PHY_DECODER -- requirements
Module: mii_phy_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for all enet_rx_* inputs, minimum 2.
REQ-002 SHALL have port i_clk  input  1  system clock; all logic runs on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous to i_clk, active-high.
REQ-004 SHALL have port enet_rx_clk  input  1  PHY receive clock; sampled as data, never used as a clock.
REQ-005 SHALL have port enet_rx_dv  input  1  PHY receive data valid.
REQ-006 SHALL have port enet_rx_er  input  1  PHY receive error.
REQ-007 SHALL have port enet_rxd  input  4  PHY receive nibble.
REQ-008 SHALL have port rx_valid  output  1  one-cycle strobe: rx_data, rx_last and rx_err valid.
REQ-009 SHALL have port rx_data  output  8  received frame byte; preamble and SFD stripped.
REQ-010 SHALL have port rx_last  output  1  with rx_valid, marks the final byte of the frame.
REQ-011 SHALL have port rx_err  output  1  with rx_valid and rx_last, frame had rx_er, an odd nibble count or a bad CRC.
REQ-012 SHALL have port rx_crc_ok  output  1  with rx_last, CRC residue correct; exists only with the CRC macro.

Function
REQ-013 SHALL pass enet_rx_clk, enet_rx_dv, enet_rx_er and enet_rxd through identical SYNC_STAGES-deep flop chains.
REQ-014 SHALL detect a rising edge on the synchronized enet_rx_clk and sample the synchronized dv, er and rxd on that i_clk cycle ("nibble event").
REQ-015 SHALL require an i_clk frequency of at least 4x enet_rx_clk; no back-pressure exists.
REQ-016 SHALL use states IDLE, PREAMBLE, DATA_LO, DATA_HI and DROP, and change state only on nibble events.
REQ-017 IDLE: dv=1 and rxd=PREAMBLE_NIB goes to PREAMBLE; dv=1 with any other nibble goes to DROP.
REQ-018 PREAMBLE: PREAMBLE_NIB stays; SFD_NIB goes to DATA_LO; any other nibble goes to DROP; dv=0 goes to IDLE with no output.
REQ-019 DATA_LO: dv=1 latches the low nibble and goes to DATA_HI.
REQ-020 DATA_HI: dv=1 forms the byte {rxd, low}; if the hold register is full, its byte is emitted with rx_last=0; the new byte enters the hold register; next state DATA_LO.
REQ-021 A one-byte hold register SHALL delay output by one byte so that rx_last can be known; byte emission occurs on the i_clk cycle after the nibble event.
REQ-022 dv=0 in DATA_LO SHALL emit the held byte with rx_last=1 and go to IDLE; no output if the hold register is empty (SFD-only frame).
REQ-023 dv=0 in DATA_HI SHALL emit the held byte with rx_last=1 and rx_err=1 (odd nibble count, partial byte discarded), then go to IDLE.
REQ-024 rx_er=1 with dv=1 in DATA_LO/DATA_HI SHALL set a sticky error flag, reported as rx_err on the rx_last byte and cleared on entering IDLE.
REQ-025 DROP: ignore all nibbles until dv=0, then go to IDLE; no output.
REQ-026 rx_valid SHALL be low when not strobing; rx_data SHALL hold its last value; rx_last and rx_err SHALL be 0 unless rx_valid=1.

Reset
REQ-027 i_reset SHALL clear the state to IDLE, empty the hold register, clear the sticky error, zero the synchronizers and drive all outputs to 0, with CRC preset to 32'hFFFFFFFF.
REQ-028 Reset during a frame SHALL abandon it without emitting rx_last; a frame already in progress at release SHALL be handled as DROP because IDLE sees dv=1 with a non-preamble nibble.

Configuration
REQ-029 With MII_RX_CRC_CHECK_EN defined, a CRC-32 SHALL run over every data byte including the FCS; rx_crc_ok=1 on rx_last when the residue equals CRC32_RESIDUE, and a mismatch SHALL also set rx_err.
REQ-030 Without MII_RX_CRC_CHECK_EN, the rx_crc_ok port and the CRC logic SHALL be absent, and rx_err SHALL reflect only rx_er and alignment errors.

Structure
REQ-031 Package net_pkg SHALL hold PREAMBLE_NIB=4'h5, SFD_NIB=4'hD, CRC32_POLY=32'h04C11DB7 (reflected 32'hEDB88320), CRC32_RESIDUE=32'hC704DD7B and the state enum.
REQ-032 The CRC SHALL be implemented in sub-module net_crc32 (byte-wide, reflected, init all-ones), shared with the encoder path.

Verification
REQ-033 Drive 15x5, then D, then the 60-byte packet from tb_net_crc32_packet.hex (low nibble first, with FCS) -> exactly 64 rx_valid strobes, bytes match the file plus FCS, rx_last only on byte 64, rx_err=0, rx_crc_ok=1.
REQ-034 Same frame with one data nibble flipped -> 64 bytes, rx_last with rx_err=1, rx_crc_ok=0.
REQ-035 Frame with one extra nibble 4'hA before dv falls -> final emitted byte is the last full byte with rx_last=1 and rx_err=1; 4'hA never appears.
REQ-036 Pulse rx_er for one nibble mid-payload -> all bytes delivered, rx_err=1 only on the rx_last byte; the next clean frame gives rx_err=0.
REQ-037 Preamble 5,5,7,... -> no rx_valid until dv falls and a new valid frame arrives; assert i_reset mid-payload -> outputs 0 next cycle, no rx_last, next frame decoded correctly.

Source files
------------

// File: rtl/net_pkg.sv
// net_pkg: constants, state type and CRC helpers shared by the MII receive
// decoder and the encoder path.
//   PREAMBLE_NIB / SFD_NIB : nibble values on the MII bus before frame data
//   CRC32_*                : Ethernet FCS polynomial, preset and residue
//   rx_state_t             : receive decoder states
//   bit_reverse32          : 32-bit bit-order reversal
//   crc32_refl_byte        : one byte step of the reflected CRC-32
package net_pkg;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Residue in the non-reflected bit order; a reflected register holds
    // the bit-reversed value after running over data plus a good FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA_LO,
        DATA_HI,
        DROP
    } rx_state_t;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC32_POLY_REFL = bit_reverse32(CRC32_POLY);

    // LSB-first byte update, matching the on-wire bit order of Ethernet.
    function automatic logic [31:0] crc32_refl_byte(input logic [31:0] crc_in,
                                                    input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/net_crc32.sv
// net_crc32: byte-wide reflected CRC-32 accumulator, preset to all-ones.
// No final inversion is applied; callers either invert for an FCS or compare
// the register against the residue.
//   i_clk   : system clock
//   i_reset : synchronous active-high reset, presets the register
//   init    : reload the preset (takes priority over en)
//   en      : fold data into the register
//   data    : byte to fold in
//   crc     : current register value
module net_crc32
    import net_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge i_clk) begin
        if (i_reset || init) begin
            crc <= CRC32_INIT;
        end else if (en) begin
            crc <= crc32_refl_byte(crc, data);
        end
    end

endmodule

// File: rtl/mii_phy_decoder.sv
// mii_phy_decoder: oversampled MII receive decoder. The PHY receive signals
// (including enet_rx_clk) are synchronised into i_clk and treated as data;
// each rising edge of the synchronised enet_rx_clk is one nibble event.
// Preamble and SFD are stripped and nibbles are paired low-first into bytes.
// A one-byte hold register delays output so the final byte can carry rx_last.
//
// Optional feature: define MII_RX_CRC_CHECK_EN to add FCS checking and the
// rx_crc_ok port. Without it, rx_err covers only rx_er and odd nibble counts.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth for all enet_rx_* inputs (2 or more)
// Ports:
//   i_clk       : system clock, at least 4x enet_rx_clk
//   i_reset     : synchronous active-high reset
//   enet_rx_clk : PHY receive clock, sampled as data
//   enet_rx_dv  : PHY receive data valid
//   enet_rx_er  : PHY receive error
//   enet_rxd    : PHY receive nibble
//   rx_valid    : one-cycle strobe qualifying rx_data/rx_last/rx_err
//   rx_data     : frame byte, holds its value between strobes
//   rx_last     : final byte of the frame
//   rx_err      : frame error, only alongside rx_last
//   rx_crc_ok   : FCS residue correct, only alongside rx_last (CRC builds)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for dv with a preamble nibble
// PREAMBLE | inside preamble, waiting for SFD
// DATA_LO  | next nibble is the low half of a byte
// DATA_HI  | next nibble completes a byte
// DROP     | malformed start, discard until dv falls
module mii_phy_decoder
    import net_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       enet_rx_clk,
    input  logic       enet_rx_dv,
    input  logic       enet_rx_er,
    input  logic [3:0] enet_rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_last,
    output logic       rx_err
`ifdef MII_RX_CRC_CHECK_EN
    ,
    output logic       rx_crc_ok
`endif
);

    // All seven inputs travel through the same chain so clock and data
    // arrive in the same i_clk cycle.
    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [6:0]                  s_bus;
    logic                        s_clk, s_dv, s_er;
    logic [3:0]                  s_rxd;
    logic                        clk_d;
    logic                        nib_evt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
            clk_d  <= 1'b0;
        end else begin
            sync_q[0] <= {enet_rx_clk, enet_rx_dv, enet_rx_er, enet_rxd};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            clk_d <= s_clk;
        end
    end

    assign s_bus   = sync_q[SYNC_STAGES-1];
    assign s_clk   = s_bus[6];
    assign s_dv    = s_bus[5];
    assign s_er    = s_bus[4];
    assign s_rxd   = s_bus[3:0];
    assign nib_evt = s_clk & ~clk_d;

    rx_state_t  state, state_n;
    logic [3:0] low_q, low_n;
    logic [7:0] hold_q, hold_n;
    logic       full_q, full_n;
    logic       err_q, err_n;
    logic       emit, emit_last, emit_err;

`ifdef MII_RX_CRC_CHECK_EN
    logic        crc_init, crc_en;
    logic [7:0]  crc_byte;
    logic [31:0] crc_val;
    logic        crc_res_ok;

    assign crc_byte   = {s_rxd, low_q};
    assign crc_res_ok = (bit_reverse32(crc_val) == CRC32_RESIDUE);

    net_crc32 u_crc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .init    (crc_init),
        .en      (crc_en),
        .data    (crc_byte),
        .crc     (crc_val)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            low_q  <= '0;
            hold_q <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            low_q  <= low_n;
            hold_q <= hold_n;
            full_q <= full_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        low_n     = low_q;
        hold_n    = hold_q;
        full_n    = full_q;
        err_n     = err_q;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_err  = 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
        crc_init  = 1'b0;
        crc_en    = 1'b0;
`endif
        if (nib_evt) begin
            case (state)
                IDLE: begin
                    if (s_dv) begin
                        state_n = (s_rxd == PREAMBLE_NIB) ? PREAMBLE : DROP;
                    end
                end
                PREAMBLE: begin
                    if (!s_dv) begin
                        state_n = IDLE;
                    end else if (s_rxd == SFD_NIB) begin
                        state_n = DATA_LO;
                        full_n  = 1'b0;
                        err_n   = 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
                        crc_init = 1'b1;
`endif
                    end else if (s_rxd != PREAMBLE_NIB) begin
                        state_n = DROP;
                    end
                end
                DATA_LO: begin
                    if (s_dv) begin
                        low_n   = s_rxd;
                        err_n   = err_q | s_er;
                        state_n = DATA_HI;
                    end else begin
                        // Frame ended on a byte boundary; an empty hold
                        // register means SFD-only, nothing to report.
                        emit      = full_q;
                        emit_last = 1'b1;
`ifdef MII_RX_CRC_CHECK_EN
                        emit_err  = err_q | ~crc_res_ok;
`else
                        emit_err  = err_q;
`endif
                        full_n    = 1'b0;
                        err_n     = 1'b0;
                        state_n   = IDLE;
                    end
                end
                DATA_HI: begin
                    if (s_dv) begin
                        emit      = full_q;
                        hold_n    = {s_rxd, low_q};
                        full_n    = 1'b1;
                        err_n     = err_q | s_er;
                        state_n   = DATA_LO;
`ifdef MII_RX_CRC_CHECK_EN
                        crc_en    = 1'b1;
`endif
                    end else begin
                        // Odd nibble count: partial byte is dropped.
                        emit      = full_q;
                        emit_last = 1'b1;
                        emit_err  = 1'b1;
                        full_n    = 1'b0;
                        err_n     = 1'b0;
                        state_n   = IDLE;
                    end
                end
                DROP: begin
                    if (!s_dv) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    full_n  = 1'b0;
                    err_n   = 1'b0;
                end
            endcase
        end
    end

    // The byte leaving is always the held one, before hold_q is overwritten.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_last   <= 1'b0;
            rx_err    <= 1'b0;
`ifdef MII_RX_CRC_CHECK_EN
            rx_crc_ok <= 1'b0;
`endif
        end else begin
            rx_valid  <= emit;
            rx_last   <= emit & emit_last;
            rx_err    <= emit & emit_last & emit_err;
            if (emit) begin
                rx_data <= hold_q;
            end
`ifdef MII_RX_CRC_CHECK_EN
            rx_crc_ok <= emit & emit_last & crc_res_ok;
`endif
        end
    end

endmodule
